// File: rtl/sparc_cond_pkg.sv
// Shared encodings for SPARC Bicc condition evaluation and next-PC selection.
package sparc_cond_pkg;

  localparam int unsigned COND_W   = 4;
  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned PC_SEL_W = 2;

  // Bicc cond field I[28:25]
  localparam logic [COND_W-1:0] COND_BN   = 4'b0000;
  localparam logic [COND_W-1:0] COND_BE   = 4'b0001;
  localparam logic [COND_W-1:0] COND_BLE  = 4'b0010;
  localparam logic [COND_W-1:0] COND_BL   = 4'b0011;
  localparam logic [COND_W-1:0] COND_BLEU = 4'b0100;
  localparam logic [COND_W-1:0] COND_BCS  = 4'b0101;
  localparam logic [COND_W-1:0] COND_BNEG = 4'b0110;
  localparam logic [COND_W-1:0] COND_BVS  = 4'b0111;
  localparam logic [COND_W-1:0] COND_BA   = 4'b1000;
  localparam logic [COND_W-1:0] COND_BNE  = 4'b1001;
  localparam logic [COND_W-1:0] COND_BG   = 4'b1010;
  localparam logic [COND_W-1:0] COND_BGE  = 4'b1011;
  localparam logic [COND_W-1:0] COND_BGU  = 4'b1100;
  localparam logic [COND_W-1:0] COND_BCC  = 4'b1101;
  localparam logic [COND_W-1:0] COND_BPOS = 4'b1110;
  localparam logic [COND_W-1:0] COND_BVC  = 4'b1111;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEQ  = 2'b00,
    PC_TGT  = 2'b01,
    PC_JMPL = 2'b10
  } pc_sel_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ANNUL = 1'b1
  } annul_state_e;

endpackage

// File: rtl/cond_evaluator.sv
// Combinational Bicc condition truth from cond field and {N,Z,V,C} flags.
module cond_evaluator
  import sparc_cond_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               truth
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    truth = 1'b0;
    case (cond)
      COND_BA:   truth = 1'b1;
      COND_BN:   truth = 1'b0;
      COND_BNE:  truth = ~z;
      COND_BE:   truth = z;
      COND_BG:   truth = ~(z | (n ^ v));
      COND_BLE:  truth = z | (n ^ v);
      COND_BGE:  truth = ~(n ^ v);
      COND_BL:   truth = n ^ v;
      COND_BGU:  truth = ~(c | z);
      COND_BLEU: truth = c | z;
      COND_BCC:  truth = ~c;
      COND_BCS:  truth = c;
      COND_BPOS: truth = ~n;
      COND_BNEG: truth = n;
      COND_BVC:  truth = ~v;
      COND_BVS:  truth = v;
      default:   truth = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves Bicc/call/jmpl in ID: icc register with EX bypass, next-PC select,
// and a one-slot annul FSM driving the CU nop-injection select S.
module branch_resolution_unit
  import sparc_cond_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                LE,
  input  logic                ID_branch_instr,
  input  logic                ID_call,
  input  logic                ID_jmpl,
  input  logic [COND_W-1:0]   cond,
  input  logic                a,
  input  logic                EX_CC_Enable,
  input  logic [FLAGS_W-1:0]  EX_flags,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                taken,
  output logic                S,
  output logic [FLAGS_W-1:0]  icc
);

  annul_state_e       state, state_nxt;
  logic [FLAGS_W-1:0] eff_flags;
  logic               cond_true;
  logic               annul;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      icc <= '0;
    end else if (LE && EX_CC_Enable) begin
      icc <= EX_flags;
    end
  end

  // Bypass lets the Bicc right behind a flag-setter see its flags now.
  assign eff_flags = EX_CC_Enable ? EX_flags : icc;

  cond_evaluator u_cond_evaluator (
    .cond  (cond),
    .flags (eff_flags),
    .truth (cond_true)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transfer priority jmpl > call > Bicc; the annulled slot is masked.
  always_comb begin
    state_nxt = state;
    pc_sel    = PC_SEQ;
    taken     = 1'b0;
    annul     = 1'b0;

    if (!clr && (state == ST_IDLE)) begin
      if (ID_jmpl) begin
        pc_sel = PC_JMPL;
        taken  = 1'b1;
      end else if (ID_call) begin
        pc_sel = PC_TGT;
        taken  = 1'b1;
      end else if (ID_branch_instr) begin
        taken  = cond_true;
        pc_sel = cond_true ? PC_TGT : PC_SEQ;
        annul  = a & ((cond == COND_BA) | ~cond_true);
      end
    end

    case (state)
      ST_IDLE:  if (LE && annul) state_nxt = ST_ANNUL;
      ST_ANNUL: if (LE) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign S = (state == ST_ANNUL) && !clr;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboarded directed test of branch_resolution_unit plus a full cond x flags sweep.
module tb_branch_resolution_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic       LE;
  logic       ID_branch_instr;
  logic       ID_call;
  logic       ID_jmpl;
  logic [3:0] cond;
  logic       a;
  logic       EX_CC_Enable;
  logic [3:0] EX_flags;
  logic [1:0] pc_sel;
  logic       taken;
  logic       S;
  logic [3:0] icc;

  typedef struct {
    string      name;
    logic [1:0] pc;
    logic       tk;
    logic       s;
    logic [3:0] icc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolution_unit dut (
    .clk             (clk),
    .clr             (clr),
    .LE              (LE),
    .ID_branch_instr (ID_branch_instr),
    .ID_call         (ID_call),
    .ID_jmpl         (ID_jmpl),
    .cond            (cond),
    .a               (a),
    .EX_CC_Enable    (EX_CC_Enable),
    .EX_flags        (EX_flags),
    .pc_sel          (pc_sel),
    .taken           (taken),
    .S               (S),
    .icc             (icc)
  );

  always #5 clk = ~clk;

  // Reference truth: low three bits pick the base test, cond[3] inverts it.
  function automatic logic ref_truth(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cd[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      default: base = v;
    endcase
    return cd[3] ? ~base : base;
  endfunction

  // One stimulus cycle: apply inputs after the edge and queue the response expected at negedge.
  task automatic drive(input string nm, input logic c_clr, input logic le,
                       input logic br, input logic cl, input logic jm,
                       input logic [3:0] cd, input logic an,
                       input logic cce, input logic [3:0] fl,
                       input logic [1:0] e_pc, input logic e_tk,
                       input logic e_s, input logic [3:0] e_icc);
    exp_t e;
    @(posedge clk);
    #1;
    clr = c_clr; LE = le; ID_branch_instr = br; ID_call = cl; ID_jmpl = jm;
    cond = cd; a = an; EX_CC_Enable = cce; EX_flags = fl;
    e.name = nm; e.pc = e_pc; e.tk = e_tk; e.s = e_s; e.icc = e_icc;
    q.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (pc_sel !== e.pc || taken !== e.tk || S !== e.s || icc !== e.icc) begin
          bad++;
          $display("FAIL %s: got pc_sel=%b taken=%b S=%b icc=%b, want pc_sel=%b taken=%b S=%b icc=%b",
                   e.name, pc_sel, taken, S, icc, e.pc, e.tk, e.s, e.icc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; LE = 1'b1; ID_branch_instr = 1'b0; ID_call = 1'b0; ID_jmpl = 1'b0;
    cond = 4'b0000; a = 1'b0; EX_CC_Enable = 1'b0; EX_flags = 4'b0000;

    //     name             clr le br cl jm cond     a  cce flags    pc     tk  s  icc
    drive("reset_hold",     1, 1, 1, 0, 0, 4'b1000, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);
    drive("bypass_be",      0, 1, 1, 0, 0, 4'b0001, 0, 1, 4'b0100, 2'b01, 1, 0, 4'b0000);
    drive("icc_loaded",     0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0100);
    drive("bne_from_icc",   0, 1, 1, 0, 0, 4'b1001, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0100);
    drive("clear_flags",    0, 1, 0, 0, 0, 4'b0000, 0, 1, 4'b0000, 2'b00, 0, 0, 4'b0100);
    drive("annul_untaken",  0, 1, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);
    drive("annul_slot",     0, 1, 1, 1, 0, 4'b1000, 1, 0, 4'b0000, 2'b00, 0, 1, 4'b0000);
    drive("after_annul",    0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);
    drive("ba_annul",       0, 1, 1, 0, 0, 4'b1000, 1, 0, 4'b0000, 2'b01, 1, 0, 4'b0000);
    drive("ba_slot",        0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b0000);
    drive("bn_annul",       0, 1, 1, 0, 0, 4'b0000, 1, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);
    drive("bn_slot",        0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b0000);
    drive("prio_jmpl",      0, 1, 1, 1, 1, 4'b1000, 1, 0, 4'b0000, 2'b10, 1, 0, 4'b0000);
    drive("prio_call",      0, 1, 1, 1, 0, 4'b0000, 1, 0, 4'b0000, 2'b01, 1, 0, 4'b0000);
    drive("no_annul_after", 0, 1, 1, 0, 0, 4'b1000, 1, 0, 4'b0000, 2'b01, 1, 0, 4'b0000);
    drive("stall_1",        0, 0, 0, 0, 0, 4'b0000, 0, 1, 4'b1111, 2'b00, 0, 1, 4'b0000);
    drive("stall_2",        0, 0, 1, 0, 0, 4'b1000, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b0000);
    drive("stall_3",        0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b0000);
    drive("stall_release",  0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b0000);
    drive("stall_done",     0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);
    drive("b2b_first",      0, 1, 1, 0, 0, 4'b0001, 1, 1, 4'b0100, 2'b01, 1, 0, 4'b0000);
    drive("b2b_delay_slot", 0, 1, 1, 0, 0, 4'b0001, 0, 0, 4'b0000, 2'b01, 1, 0, 4'b0100);
    drive("bne_annul",      0, 1, 1, 0, 0, 4'b1001, 1, 0, 4'b0000, 2'b00, 0, 0, 4'b0100);
    drive("clr_mid_annul",  1, 1, 1, 0, 0, 4'b1000, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);
    drive("post_clr",       0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000);

    // Sweep with LE=0 so neither icc nor the FSM moves; flags arrive via bypass.
    for (int cv = 0; cv < 16; cv++) begin
      for (int fv = 0; fv < 16; fv++) begin
        logic t;
        t = ref_truth(4'(cv), 4'(fv));
        drive($sformatf("sweep_c%0d_f%0d", cv, fv), 0, 0, 1, 0, 0, 4'(cv), 0, 1, 4'(fv),
              t ? 2'b01 : 2'b00, t, 0, 4'b0000);
      end
    end

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
